// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//   Shares one WIDTH-bit adder between NREQ requesters. A round-robin arbiter
//   picks one valid requester in IDLE, its operands are captured, the sum is
//   computed in CALC, and the result is presented in RESP together with the
//   winner's ID until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   req_valid  [NREQ]        requester i has operands
//   req_ready  [NREQ]        requester i accepted this cycle (one-hot or zero)
//   req_a      [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand b, same packing
//   rsp_valid  result available
//   rsp_ready  consumer takes result
//   rsp_id     [IDW]         requester that owns the result
//   rsp_sum    [WIDTH]       (a+b) mod 2^WIDTH
//   rsp_carry  carry-out of a+b
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_carry;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_rr_next;
  logic             w_accept;

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin : winner_search
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  // Grant only in IDLE and never while reset is held, so a requester cannot
  // see a handshake that the register bank will throw away.
  assign w_accept  = rst_n && (r_state == IDLE) && w_found;
  assign w_rr_next = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found)   w_state_next = CALC;
      CALC:                   w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a      <= req_a[w_winner*WIDTH +: WIDTH];
            r_b      <= req_b[w_winner*WIDTH +: WIDTH];
            r_id     <= w_winner;
            r_rr_ptr <= w_rr_next;
          end
        end
        CALC: begin
          // Widen by one bit so the carry-out lands in r_rsp_carry.
          {r_rsp_carry, r_rsp_sum} <= {1'b0, r_a} + {1'b0, r_b};
          r_rsp_id                 <= r_id;
          r_rsp_valid              <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//   Directed bench for adder_share_arbiter (WIDTH=6, NREQ=4). Inputs change
//   2 time units after the rising edge; outputs are compared 1 unit later.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int WIDTH = 6;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  int n_checks = 0;
  int n_errors = 0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One full transaction with rsp_ready=1: grant, CALC, RESP, back to IDLE.
  // keep=1 leaves the winner's req_valid asserted (continuous requester).
  task automatic txn(input string tag, input logic [NREQ-1:0] vmask, input int gid,
                     input logic [WIDTH-1:0] esum, input logic ecarry, input bit keep);
    logic [NREQ-1:0] exp_grant;
    exp_grant      = '0;
    exp_grant[gid] = 1'b1;
    req_valid = vmask;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, req_ready, exp_grant);
    tick();                                    // accept edge
    if (!keep) req_valid[gid] = 1'b0;
    #1;
    check({tag, "_calc_ready"}, req_ready, 0);
    check({tag, "_calc_valid"}, rsp_valid, 0);
    tick();                                    // CALC -> RESP
    #1;
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_id"},    rsp_id,    gid);
    check({tag, "_sum"},   rsp_sum,   esum);
    check({tag, "_carry"}, rsp_carry, ecarry);
    check({tag, "_resp_ready"}, req_ready, 0);
    tick();                                    // consumer accepts
    #1;
    check({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    set_ops(0, 6'd5,  6'd3);    // 8,  carry 0
    set_ops(1, 6'd20, 6'd30);   // 50, carry 0
    set_ops(2, 6'd61, 6'd62);   // 123 -> 59, carry 1
    set_ops(3, 6'd40, 6'd40);   // 80  -> 16, carry 1
    tick();
    tick();

    // ---- reset state ----
    check("rst_valid", rsp_valid, 0);
    check("rst_sum",   rsp_sum,   0);
    check("rst_id",    rsp_id,    0);
    check("rst_carry", rsp_carry, 0);
    req_valid = 4'b1111;
    #1;
    check("rst_ready_held", req_ready, 0);

    // ---- reset mid-CALC ----
    req_valid = 4'b0100;
    rst_n     = 1'b1;
    #1;
    check("calc_rst_grant", req_ready, 4'b0100);
    tick();                                    // accept req2, rr_ptr -> 3
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("calc_rst_ready", req_ready, 0);
    tick();
    check("calc_rst_valid", rsp_valid, 0);
    check("calc_rst_sum",   rsp_sum,   0);
    check("calc_rst_id",    rsp_id,    0);
    rst_n = 1'b1;
    #1;
    check("calc_rst_rrptr", req_ready, 4'b0001);

    // ---- reset mid-RESP ----
    tick();                                    // accept req0
    tick();                                    // now RESP
    #1;
    check("resp_rst_pre_valid", rsp_valid, 1);
    check("resp_rst_pre_sum",   rsp_sum,   6'd8);
    rst_n = 1'b0;
    #1;
    check("resp_rst_ready", req_ready, 0);
    tick();
    check("resp_rst_valid", rsp_valid, 0);
    check("resp_rst_sum",   rsp_sum,   0);
    check("resp_rst_id",    rsp_id,    0);
    check("resp_rst_carry", rsp_carry, 0);
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    check("resp_rst_idle_ready", req_ready, 0);

    // ---- basic sum, latency ----
    txn("t2", 4'b0001, 0, 6'b001000, 1'b0, 1'b0);

    // ---- wrap with carry, requester 2 ----
    txn("t3a", 4'b0100, 2, 6'b111011, 1'b1, 1'b0);
    set_ops(2, 6'b001000, 6'b111011);
    txn("t3b", 4'b0100, 2, 6'b000011, 1'b1, 1'b0);

    // ---- rsp_ready with no response pending is ignored ----
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    tick();
    check("idle_rsp_ready_valid", rsp_valid, 0);
    check("idle_rsp_ready_ready", req_ready, 0);

    // ---- all valid: rotation 0,1,2,3,0 from reset ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ops(2, 6'd61, 6'd62);
    txn("rr0", 4'b1111, 0, 6'd8,  1'b0, 1'b1);
    txn("rr1", 4'b1111, 1, 6'd50, 1'b0, 1'b1);
    txn("rr2", 4'b1111, 2, 6'd59, 1'b1, 1'b1);
    txn("rr3", 4'b1111, 3, 6'd16, 1'b1, 1'b1);
    txn("rr4", 4'b1111, 0, 6'd8,  1'b0, 1'b1);  // rr_ptr wrapped 3 -> 0

    // ---- backpressure: rr_ptr=1, req1 only ----
    set_ops(1, 6'b011001, 6'b100010);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", req_ready, 4'b0010);
    tick();                                    // accept req1, rr_ptr -> 2
    tick();                                    // RESP
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_sum",   rsp_sum,   6'b111011);
      check("bp_carry", rsp_carry, 0);
      check("bp_id",    rsp_id,    1);
      check("bp_ready", req_ready, 0);
      tick();
    end

    // ---- req3 pulses during RESP, then only req1 with rr_ptr=2 ----
    req_valid = 4'b1010;
    #1;
    check("drop_resp_ready", req_ready, 0);
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    check("drop_release_ready", req_ready, 0);
    check("drop_release_valid", rsp_valid, 1);
    tick();                                    // back to IDLE
    txn("drop", 4'b0010, 1, 6'b111011, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
